hazard_pipe_regs: RTL and testbench

Front-end pipeline register bank that consumes the hazard unit's controls: stallPC, IFID_stall, IFID_flush and IDEX_flush.
- Holds the PC register, the IF/ID register and the ID/EX register.
- Applies hold (stall) and bubble insertion (flush) with a fixed priority.
- Redirects the PC on a taken branch resolved in EX.
- Counts stall and flush cycles for performance debug.
- Sits between instruction memory/decode and the EX stage of the 5-stage pipeline.

---
 rtl/hazard_pipe_regs_pkg.sv | 24 ++
 rtl/hazard_pipe_regs_if.sv | 64 ++++++
 rtl/hazard_pipe_regs_pipe_reg_sf.sv | 24 ++
 rtl/hazard_pipe_regs.sv | 94 +++++++++
 tb/tb_hazard_pipe_regs.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pipe_regs_pkg.sv
// Shared constants for the front-end pipeline register bank: NOP encoding,
// PC step and the layout of the packed ID control bundle.
package hazard_pipe_regs_pkg;

    // All-zero word doubles as the bubble instruction
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Sequential fetch advances by one 32-bit word
    localparam int PC_INCR = 4;

    // Packed control bundle width and field positions
    localparam int CTRL_BUNDLE_W = 8;
    localparam int MEMTOREG_LSB  = 0;
    localparam int MEMTOREG_MSB  = 1;

    // memtoReg encoding that marks a load (what the hazard unit looks for)
    localparam logic [1:0] MEMTOREG_LOAD = 2'b01;

    // Extract the memtoReg field from a control bundle
    function automatic logic [1:0] memtoRegOf(input logic [CTRL_BUNDLE_W-1:0] ctrl);
        return ctrl[MEMTOREG_MSB:MEMTOREG_LSB];
    endfunction

endpackage

// File: rtl/hazard_pipe_regs_if.sv
// Bus between the hazard unit / fetch / decode logic and the pipeline
// register bank. The master drives the controls and ID fields; the slave
// (the register bank) drives the registered PC, IF/ID, ID/EX and counters.
interface hazard_pipe_regs_if #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
);
    logic              stallPC;
    logic              IFID_stall;
    logic              IFID_flush;
    logic              IDEX_flush;
    logic              EX_PCSrc;
    logic [WIDTH-1:0]  EX_branchTarget;
    logic [WIDTH-1:0]  IF_instr;

    logic [WIDTH-1:0]  pc_o;
    logic [WIDTH-1:0]  IFID_pc;
    logic [WIDTH-1:0]  IFID_instr;
    logic              IFID_valid;

    logic [CTRL_W-1:0] ID_ctrl;
    logic [WIDTH-1:0]  ID_rs1data;
    logic [WIDTH-1:0]  ID_rs2data;
    logic [WIDTH-1:0]  ID_imm;
    logic [4:0]        ID_readReg1;
    logic [4:0]        ID_readReg2;
    logic [4:0]        ID_writeReg;

    logic [CTRL_W-1:0] IDEX_ctrl;
    logic [WIDTH-1:0]  IDEX_rs1data;
    logic [WIDTH-1:0]  IDEX_rs2data;
    logic [WIDTH-1:0]  IDEX_imm;
    logic [4:0]        IDEX_readReg1;
    logic [4:0]        IDEX_readReg2;
    logic [4:0]        IDEX_writeReg;
    logic              IDEX_valid;

    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output stallPC, IFID_stall, IFID_flush, IDEX_flush, EX_PCSrc,
               EX_branchTarget, IF_instr,
               ID_ctrl, ID_rs1data, ID_rs2data, ID_imm,
               ID_readReg1, ID_readReg2, ID_writeReg,
        input  pc_o, IFID_pc, IFID_instr, IFID_valid,
               IDEX_ctrl, IDEX_rs1data, IDEX_rs2data, IDEX_imm,
               IDEX_readReg1, IDEX_readReg2, IDEX_writeReg, IDEX_valid,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  stallPC, IFID_stall, IFID_flush, IDEX_flush, EX_PCSrc,
               EX_branchTarget, IF_instr,
               ID_ctrl, ID_rs1data, ID_rs2data, ID_imm,
               ID_readReg1, ID_readReg2, ID_writeReg,
        output pc_o, IFID_pc, IFID_instr, IFID_valid,
               IDEX_ctrl, IDEX_rs1data, IDEX_rs2data, IDEX_imm,
               IDEX_readReg1, IDEX_readReg2, IDEX_writeReg, IDEX_valid,
               stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_pipe_regs_pipe_reg_sf.sv
// Generic pipeline register with synchronous reset, hold (stall) and
// clear-to-zero (flush). Flush beats stall so a squashed slot never
// keeps a stale instruction alive.
module pipe_reg_sf #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear on reset/flush, otherwise load unless held
    always_ff @(posedge clk_i) begin
        if (rst_i || flush) begin
            q <= '0;
        end else if (!stall) begin
            q <= d;
        end
    end

endmodule

// File: rtl/hazard_pipe_regs.sv
// Front-end pipeline register bank: PC, IF/ID and ID/EX registers driven by
// the hazard unit's stall/flush controls, plus branch redirect and
// saturating stall/flush performance counters.
module hazard_pipe_regs
    import hazard_pipe_regs_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               CTRL_W   = CTRL_BUNDLE_W,
    parameter logic [WIDTH-1:0] PC_RESET = '0,
    parameter int               CNT_W    = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    hazard_pipe_regs_if.slave bus
);

    localparam int IFID_W = 1 + 2 * WIDTH;
    localparam int IDEX_W = 1 + CTRL_W + 3 * WIDTH + 15;

    logic [WIDTH-1:0]  pcReg_p0;
    logic [IFID_W-1:0] ifidD;
    logic [IFID_W-1:0] ifidQ_p1;
    logic [IDEX_W-1:0] idexD;
    logic [IDEX_W-1:0] idexQ_p2;
    logic [CNT_W-1:0]  stallCnt;
    logic [CNT_W-1:0]  flushCnt;

    // Counters stick at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // ---- PC stage: redirect beats stall, otherwise step (wraps naturally)
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pcReg_p0 <= PC_RESET;
        end else if (bus.EX_PCSrc) begin
            pcReg_p0 <= bus.EX_branchTarget;
        end else if (!bus.stallPC) begin
            pcReg_p0 <= pcReg_p0 + WIDTH'(PC_INCR);
        end
    end

    // ---- IF/ID stage: loads the fetched word tagged with its PC as valid
    assign ifidD = {1'b1, pcReg_p0, bus.IF_instr};

    pipe_reg_sf #(.WIDTH(IFID_W)) uIfid (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .stall (bus.IFID_stall),
        .flush (bus.IFID_flush),
        .d     (ifidD),
        .q     (ifidQ_p1)
    );

    // ---- ID/EX stage: never held; a flush produces an all-zero bubble whose
    // memtoReg and writeReg are zero, so it cannot look like a load
    assign idexD = {ifidQ_p1[IFID_W-1], bus.ID_ctrl,
                    bus.ID_rs1data, bus.ID_rs2data, bus.ID_imm,
                    bus.ID_readReg1, bus.ID_readReg2, bus.ID_writeReg};

    pipe_reg_sf #(.WIDTH(IDEX_W)) uIdex (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .stall (1'b0),
        .flush (bus.IDEX_flush),
        .d     (idexD),
        .q     (idexQ_p2)
    );

    // Performance counters: a stall cycle only counts when not overridden by a redirect
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (bus.stallPC && !bus.EX_PCSrc) begin
                stallCnt <= satInc(stallCnt);
            end
            if (bus.EX_PCSrc) begin
                flushCnt <= satInc(flushCnt);
            end
        end
    end

    assign bus.pc_o = pcReg_p0;
    assign {bus.IFID_valid, bus.IFID_pc, bus.IFID_instr} = ifidQ_p1;
    assign {bus.IDEX_valid, bus.IDEX_ctrl,
            bus.IDEX_rs1data, bus.IDEX_rs2data, bus.IDEX_imm,
            bus.IDEX_readReg1, bus.IDEX_readReg2, bus.IDEX_writeReg} = idexQ_p2;
    assign bus.stall_cnt = stallCnt;
    assign bus.flush_cnt = flushCnt;

endmodule

// File: tb/tb_hazard_pipe_regs.sv
// Bench for hazard_pipe_regs: directed scenarios with literal expectations,
// then randomized control/data traffic compared every cycle against a
// behavioural model of the PC / IF/ID / ID/EX rules.
module tb_hazard_pipe_regs;
    import hazard_pipe_regs_pkg::*;

    localparam int WIDTH  = 32;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic clk;
    logic rst;
    int   nCmp = 0;
    int   nBad = 0;
    bit   chkEn = 0;

    hazard_pipe_regs_if #(.WIDTH(WIDTH), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

    hazard_pipe_regs #(
        .WIDTH(WIDTH), .CTRL_W(CTRL_W), .PC_RESET(32'h0), .CNT_W(CNT_W)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Behavioural model state
    logic [31:0] mPc, mIfPc, mIfInstr, mRs1, mRs2, mImm;
    logic        mIfV, mExV;
    logic [7:0]  mCtrl;
    logic [4:0]  mR1, mR2, mWr;
    int          mSc, mFc;

    // Model: next state from the rules, using values seen before the edge
    always @(posedge clk) begin
        if (rst) begin
            mPc <= 32'h0; mIfPc <= 0; mIfInstr <= 0; mIfV <= 0;
            mExV <= 0; mCtrl <= 0; mRs1 <= 0; mRs2 <= 0; mImm <= 0;
            mR1 <= 0; mR2 <= 0; mWr <= 0; mSc <= 0; mFc <= 0;
        end else begin
            if (bus.EX_PCSrc)      mPc <= bus.EX_branchTarget;
            else if (!bus.stallPC) mPc <= 32'((64'(mPc) + 64'd4) % 64'h1_0000_0000);
            if (bus.IFID_flush) begin
                mIfV <= 0; mIfPc <= 0; mIfInstr <= NOP_INSTR;
            end else if (!bus.IFID_stall) begin
                mIfV <= 1; mIfPc <= mPc; mIfInstr <= bus.IF_instr;
            end
            if (bus.IDEX_flush) begin
                mExV <= 0; mCtrl <= 0; mRs1 <= 0; mRs2 <= 0; mImm <= 0;
                mR1 <= 0; mR2 <= 0; mWr <= 0;
            end else begin
                mExV <= mIfV; mCtrl <= bus.ID_ctrl; mRs1 <= bus.ID_rs1data;
                mRs2 <= bus.ID_rs2data; mImm <= bus.ID_imm;
                mR1 <= bus.ID_readReg1; mR2 <= bus.ID_readReg2; mWr <= bus.ID_writeReg;
            end
            if (bus.stallPC && !bus.EX_PCSrc) mSc <= (mSc < CMAX) ? mSc + 1 : CMAX;
            if (bus.EX_PCSrc)                 mFc <= (mFc < CMAX) ? mFc + 1 : CMAX;
        end
    end

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chkEn) begin
            cmp("pc_o", 64'(bus.pc_o), 64'(mPc));
            cmp("IFID_pc", 64'(bus.IFID_pc), 64'(mIfPc));
            cmp("IFID_instr", 64'(bus.IFID_instr), 64'(mIfInstr));
            cmp("IFID_valid", 64'(bus.IFID_valid), 64'(mIfV));
            cmp("IDEX_valid", 64'(bus.IDEX_valid), 64'(mExV));
            cmp("IDEX_ctrl", 64'(bus.IDEX_ctrl), 64'(mCtrl));
            cmp("IDEX_rs1data", 64'(bus.IDEX_rs1data), 64'(mRs1));
            cmp("IDEX_rs2data", 64'(bus.IDEX_rs2data), 64'(mRs2));
            cmp("IDEX_imm", 64'(bus.IDEX_imm), 64'(mImm));
            cmp("IDEX_readReg1", 64'(bus.IDEX_readReg1), 64'(mR1));
            cmp("IDEX_readReg2", 64'(bus.IDEX_readReg2), 64'(mR2));
            cmp("IDEX_writeReg", 64'(bus.IDEX_writeReg), 64'(mWr));
            cmp("stall_cnt", 64'(bus.stall_cnt), 64'(mSc));
            cmp("flush_cnt", 64'(bus.flush_cnt), 64'(mFc));
        end
    end

    // Apply one cycle of controls with fresh random fetch/decode data
    task automatic cyc(input bit r, input bit sp, input bit is, input bit ifl,
                       input bit idf, input bit br, input logic [31:0] tgt);
        rst = r;
        bus.stallPC = sp; bus.IFID_stall = is; bus.IFID_flush = ifl;
        bus.IDEX_flush = idf; bus.EX_PCSrc = br; bus.EX_branchTarget = tgt;
        bus.IF_instr = $urandom;
        bus.ID_ctrl = 8'($urandom);
        bus.ID_rs1data = $urandom; bus.ID_rs2data = $urandom; bus.ID_imm = $urandom;
        bus.ID_readReg1 = 5'($urandom); bus.ID_readReg2 = 5'($urandom);
        bus.ID_writeReg = 5'($urandom);
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset then free run
        cyc(1, 0, 0, 0, 0, 0, 0);
        chkEn = 1;
        cyc(1, 0, 0, 0, 0, 0, 0);
        cmp("rst pc_o", 64'(bus.pc_o), 64'h0);
        cmp("rst IFID_valid", 64'(bus.IFID_valid), 64'h0);
        cmp("rst IDEX_valid", 64'(bus.IDEX_valid), 64'h0);
        cmp("rst IFID_instr", 64'(bus.IFID_instr), 64'h0);
        cmp("rst stall_cnt", 64'(bus.stall_cnt), 64'h0);
        cmp("rst flush_cnt", 64'(bus.flush_cnt), 64'h0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cmp("run1 pc_o", 64'(bus.pc_o), 64'h4);
        cmp("run1 IFID_valid", 64'(bus.IFID_valid), 64'h1);
        cmp("run1 IFID_pc", 64'(bus.IFID_pc), 64'h0);
        cmp("run1 IDEX_valid", 64'(bus.IDEX_valid), 64'h0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cmp("run2 pc_o", 64'(bus.pc_o), 64'h8);
        cmp("run2 IDEX_valid", 64'(bus.IDEX_valid), 64'h1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cmp("run3 pc_o", 64'(bus.pc_o), 64'hC);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cmp("pre-lu pc_o", 64'(bus.pc_o), 64'h10);
        cmp("pre-lu IFID_pc", 64'(bus.IFID_pc), 64'hC);
        cmp("run cnt", 64'(bus.stall_cnt) + 64'(bus.flush_cnt), 64'h0);

        // Load-use: hold PC and IF/ID, bubble into EX
        cyc(0, 1, 1, 0, 1, 0, 0);
        cmp("lu pc_o", 64'(bus.pc_o), 64'h10);
        cmp("lu IFID_pc", 64'(bus.IFID_pc), 64'hC);
        cmp("lu IDEX_valid", 64'(bus.IDEX_valid), 64'h0);
        cmp("lu IDEX_ctrl", 64'(bus.IDEX_ctrl), 64'h0);
        cmp("lu memtoReg not load", 64'(memtoRegOf(bus.IDEX_ctrl) == MEMTOREG_LOAD), 64'h0);
        cmp("lu stall_cnt", 64'(bus.stall_cnt), 64'h1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cmp("post-lu pc_o", 64'(bus.pc_o), 64'h14);
        cmp("post-lu IFID_pc", 64'(bus.IFID_pc), 64'h10);
        cmp("post-lu IDEX_valid", 64'(bus.IDEX_valid), 64'h1);

        // Taken branch squashes two younger instructions
        cyc(0, 0, 0, 1, 1, 1, 32'h40);
        cmp("br pc_o", 64'(bus.pc_o), 64'h40);
        cmp("br IFID_valid", 64'(bus.IFID_valid), 64'h0);
        cmp("br IFID_instr", 64'(bus.IFID_instr), 64'(NOP_INSTR));
        cmp("br IDEX_valid", 64'(bus.IDEX_valid), 64'h0);
        cmp("br flush_cnt", 64'(bus.flush_cnt), 64'h1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cmp("post-br pc_o", 64'(bus.pc_o), 64'h44);
        cmp("post-br IFID_pc", 64'(bus.IFID_pc), 64'h40);
        cmp("post-br IDEX_valid", 64'(bus.IDEX_valid), 64'h0);

        // Stall and branch together: redirect and flush win
        cyc(0, 1, 1, 1, 0, 1, 32'h80);
        cmp("sb pc_o", 64'(bus.pc_o), 64'h80);
        cmp("sb IFID_valid", 64'(bus.IFID_valid), 64'h0);
        cmp("sb stall_cnt", 64'(bus.stall_cnt), 64'h1);
        cmp("sb flush_cnt", 64'(bus.flush_cnt), 64'h2);

        // PC wrap, then reset in the middle of a stall
        cyc(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        cmp("wrap pre pc_o", 64'(bus.pc_o), 64'hFFFF_FFFC);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cmp("wrap pc_o", 64'(bus.pc_o), 64'h0);
        cyc(0, 1, 1, 0, 0, 0, 0);
        cmp("wrap stall_cnt", 64'(bus.stall_cnt), 64'h2);
        cyc(1, 1, 1, 0, 1, 1, 32'h1234);
        cmp("mid-rst pc_o", 64'(bus.pc_o), 64'h0);
        cmp("mid-rst IFID_valid", 64'(bus.IFID_valid), 64'h0);
        cmp("mid-rst IDEX_valid", 64'(bus.IDEX_valid), 64'h0);
        cmp("mid-rst stall_cnt", 64'(bus.stall_cnt), 64'h0);
        cmp("mid-rst flush_cnt", 64'(bus.flush_cnt), 64'h0);

        // Counter saturation
        for (int i = 1; i <= 20; i++) begin
            cyc(0, 1, 0, 0, 0, 0, 0);
            if (i == 14) cmp("sat 14", 64'(bus.stall_cnt), 64'd14);
            if (i == 15) cmp("sat 15", 64'(bus.stall_cnt), 64'd15);
        end
        cmp("sat hold", 64'(bus.stall_cnt), 64'd15);
        cmp("sat pc_o", 64'(bus.pc_o), 64'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] t;
            t = $urandom;
            if ($urandom_range(0, 3) != 0) t = t & 32'hFFFF_FFFC;
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 7) == 0), t);
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
